// File: rtl/bsg_gateway_reset_seq_if.sv
// rtl/bsg_gateway_reset_seq_if.sv - lock/restart inputs and sequenced reset outputs of the gateway reset sequencer
//
// Signals:
//   locked_i       combined clock-generator lock, asynchronous to the sequencer clock
//   sw_reset_i     level-sensitive software restart request, synchronous
//   reset_o        active-high per-domain resets, bit 0 releases first
//   done_o         all stages released
//   relock_count_o saturating count of qualified lock-loss events
// Modports:
//   master  drives locked_i/sw_reset_i, observes the outputs
//   slave   the sequencer side
interface bsg_gateway_reset_seq_if #(
  parameter int num_stages_p = 4
);
  logic                    locked_i;
  logic                    sw_reset_i;
  logic [num_stages_p-1:0] reset_o;
  logic                    done_o;
  logic [7:0]              relock_count_o;

  modport master (
    output locked_i,
    output sw_reset_i,
    input  reset_o,
    input  done_o,
    input  relock_count_o
  );

  modport slave (
    input  locked_i,
    input  sw_reset_i,
    output reset_o,
    output done_o,
    output relock_count_o
  );
endinterface

// File: rtl/bsg_gateway_reset_seq.sv
// rtl/bsg_gateway_reset_seq.sv - lock-qualified, staged reset release sequencer
//
// Ports:
//   clk_i      single clock; every output is registered on its rising edge
//   reset_n_i  asynchronous active-low reset
//   bus        slave side of bsg_gateway_reset_seq_if (locked_i, sw_reset_i in;
//              reset_o, done_o, relock_count_o out)
// Parameters:
//   lock_filter_p  consecutive synchronized-lock cycles before release starts (>= 1)
//   stage_delay_p  cycles between successive reset deassertions (>= 1)
//   num_stages_p   number of sequenced reset outputs (1..8)
module bsg_gateway_reset_seq #(
  parameter int lock_filter_p = 1024,
  parameter int stage_delay_p = 256,
  parameter int num_stages_p  = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  bsg_gateway_reset_seq_if.slave  bus
);

  localparam int max_cnt_lp = (lock_filter_p > stage_delay_p) ? lock_filter_p : stage_delay_p;
  localparam int cnt_w_lp   = $clog2(max_cnt_lp + 1);

  localparam logic [cnt_w_lp-1:0] filter_last_lp = cnt_w_lp'(lock_filter_p - 1);
  localparam logic [cnt_w_lp-1:0] stage_last_lp  = cnt_w_lp'(stage_delay_p - 1);
  localparam logic [2:0]          idx_last_lp    = 3'(num_stages_p - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK,
    FILTER,
    RELEASE,
    DONE
  } state_e;

  state_e                  state_r, state_n;
  logic [cnt_w_lp-1:0]     cnt_r, cnt_n;
  logic [2:0]              idx_r, idx_n;
  logic [num_stages_p-1:0] rst_r, rst_n;
  logic                    done_r, done_n;
  logic [7:0]              relock_r, relock_n;

  // Two-flop synchronizer; locked_s is the only view of locked_i used below.
  logic sync_meta, locked_s;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      sync_meta <= bus.locked_i;
      locked_s  <= sync_meta;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r  <= WAIT_LOCK;
      cnt_r    <= '0;
      idx_r    <= '0;
      rst_r    <= '1;
      done_r   <= 1'b0;
      relock_r <= '0;
    end else begin
      state_r  <= state_n;
      cnt_r    <= cnt_n;
      idx_r    <= idx_n;
      rst_r    <= rst_n;
      done_r   <= done_n;
      relock_r <= relock_n;
    end
  end

  // sw_reset_i wins over lock: either one ends any qualified state.
  logic abort;
  assign abort = bus.sw_reset_i || !locked_s;

  always_comb begin
    state_n  = state_r;
    cnt_n    = cnt_r;
    idx_n    = idx_r;
    rst_n    = rst_r;
    done_n   = done_r;
    relock_n = relock_r;

    unique case (state_r)
      WAIT_LOCK: begin
        rst_n  = '1;
        done_n = 1'b0;
        if (!abort) begin
          state_n = FILTER;
          cnt_n   = '0;
        end
      end
      FILTER: begin
        if (cnt_r == filter_last_lp) begin
          state_n = RELEASE;
          cnt_n   = '0;
          idx_n   = '0;
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      RELEASE: begin
        if (cnt_r == stage_last_lp) begin
          cnt_n = '0;
          idx_n = idx_r + 3'd1;
          for (int i = 0; i < num_stages_p; i++) begin
            if (idx_r == 3'(i)) rst_n[i] = 1'b0;
          end
          // Last stage: done_o rises on the same edge the final bit falls.
          if (idx_r == idx_last_lp) begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          cnt_n = cnt_r + cnt_w_lp'(1);
        end
      end
      DONE: begin
        rst_n  = '0;
        done_n = 1'b1;
      end
      default: begin
        state_n = WAIT_LOCK;
      end
    endcase

    // Abort overrides whatever the qualified states computed above.
    if (abort && state_r != WAIT_LOCK) begin
      state_n = WAIT_LOCK;
      cnt_n   = '0;
      idx_n   = '0;
      rst_n   = '1;
      done_n  = 1'b0;
      // Only losing lock after qualification counts, even if sw_reset_i is also high.
      if (!locked_s && (state_r == RELEASE || state_r == DONE) && relock_r != 8'hFF) begin
        relock_n = relock_r + 8'd1;
      end
    end
  end

  assign bus.reset_o        = rst_r;
  assign bus.done_o         = done_r;
  assign bus.relock_count_o = relock_r;

endmodule

// File: tb/tb_bsg_gateway_reset_seq.sv
// tb/tb_bsg_gateway_reset_seq.sv - self-checking bench for bsg_gateway_reset_seq
module tb_bsg_gateway_reset_seq;

  localparam int F = 8;
  localparam int D = 4;
  localparam int N = 3;

  logic clk_i = 1'b0;
  logic reset_n_i;
  int   checks = 0;
  int   errors = 0;
  int   ecnt   = 0;

  always #5 clk_i = ~clk_i;

  bsg_gateway_reset_seq_if #(.num_stages_p(N)) bus ();

  bsg_gateway_reset_seq #(
    .lock_filter_p(F),
    .stage_delay_p(D),
    .num_stages_p (N)
  ) dut (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .bus      (bus)
  );

  typedef struct {
    int         edge_n;
    logic [2:0] rst;
    logic       done;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
    ecnt++;
  endtask

  // Edges are relative to the first edge that samples locked_i high.
  task automatic run_table(input int shift, input string tag);
    for (int v = 0; v < 8; v++) begin
      while (ecnt < tbl[v].edge_n + shift) tick();
      chk($sformatf("%s reset_o@%0d", tag, ecnt), 32'(bus.reset_o), 32'(tbl[v].rst));
      chk($sformatf("%s done_o@%0d", tag, ecnt), 32'(bus.done_o), 32'(tbl[v].done));
    end
  endtask

  initial begin
    int  n;
    bit  ok;

    tbl[0] = '{3,  3'b111, 1'b0};
    tbl[1] = '{14, 3'b111, 1'b0};
    tbl[2] = '{15, 3'b110, 1'b0};
    tbl[3] = '{18, 3'b110, 1'b0};
    tbl[4] = '{19, 3'b100, 1'b0};
    tbl[5] = '{22, 3'b100, 1'b0};
    tbl[6] = '{23, 3'b000, 1'b1};
    tbl[7] = '{26, 3'b000, 1'b1};

    // Reset state
    reset_n_i      = 1'b0;
    bus.locked_i   = 1'b0;
    bus.sw_reset_i = 1'b0;
    #12;
    chk("reset reset_o", 32'(bus.reset_o), 32'h7);
    chk("reset done_o", 32'(bus.done_o), 32'h0);
    chk("reset relock", 32'(bus.relock_count_o), 32'h0);
    #1 reset_n_i = 1'b1;
    tick();
    tick();
    chk("unlocked reset_o", 32'(bus.reset_o), 32'h7);

    // Basic release sequence
    bus.locked_i = 1'b1;
    ecnt = 0;
    run_table(0, "seq1");
    chk("seq1 relock", 32'(bus.relock_count_o), 32'h0);

    // Lock loss in DONE
    bus.locked_i = 1'b0;
    ecnt = 0;
    tick();
    tick();
    chk("drop e2 reset_o", 32'(bus.reset_o), 32'h0);
    chk("drop e2 done_o", 32'(bus.done_o), 32'h1);
    tick();
    chk("drop e3 reset_o", 32'(bus.reset_o), 32'h7);
    chk("drop e3 done_o", 32'(bus.done_o), 32'h0);
    chk("drop e3 relock", 32'(bus.relock_count_o), 32'h1);
    bus.locked_i = 1'b1;
    ecnt = 0;
    run_table(0, "relock");

    // sw_reset held three edges in DONE: abort, stay in WAIT_LOCK, no count
    bus.sw_reset_i = 1'b1;
    ecnt = 0;
    tick();
    chk("sw e1 reset_o", 32'(bus.reset_o), 32'h7);
    chk("sw e1 done_o", 32'(bus.done_o), 32'h0);
    chk("sw e1 relock", 32'(bus.relock_count_o), 32'h1);
    tick();
    tick();
    chk("sw e3 reset_o", 32'(bus.reset_o), 32'h7);
    bus.sw_reset_i = 1'b0;
    run_table(1, "sw");
    chk("sw relock", 32'(bus.relock_count_o), 32'h1);

    // One-cycle drop in DONE (counts), then one-cycle drop mid-FILTER (no count, filter restarts)
    bus.locked_i = 1'b0;
    ecnt = 0;
    tick();
    bus.locked_i = 1'b1;
    tick();
    tick();
    chk("glitch e3 reset_o", 32'(bus.reset_o), 32'h7);
    chk("glitch e3 relock", 32'(bus.relock_count_o), 32'h2);
    while (ecnt < 6) tick();
    bus.locked_i = 1'b0;
    tick();
    bus.locked_i = 1'b1;
    run_table(7, "filt");
    chk("filt relock", 32'(bus.relock_count_o), 32'h2);

    // 300 lock-loss events from DONE: saturate at 255
    for (int k = 1; k <= 300; k++) begin
      bus.locked_i = 1'b0;
      tick();
      bus.locked_i = 1'b1;
      n = 0;
      while (bus.done_o !== 1'b0 && n < 10) begin tick(); n++; end
      ok = (bus.done_o === 1'b0);
      n = 0;
      while (bus.done_o !== 1'b1 && n < 60) begin tick(); n++; end
      if (!(ok && bus.done_o === 1'b1)) chk($sformatf("sat timeout k=%0d", k), 32'(0), 32'(1));
      if (k == 250) chk("sat relock k=250", 32'(bus.relock_count_o), 32'd252);
    end
    chk("sat relock", 32'(bus.relock_count_o), 32'd255);

    // Async reset mid-RELEASE
    bus.sw_reset_i = 1'b1;
    ecnt = 0;
    tick();
    bus.sw_reset_i = 1'b0;
    while (ecnt < 13) tick();
    chk("mid e13 reset_o", 32'(bus.reset_o), 32'h7);
    tick();
    chk("mid e14 reset_o", 32'(bus.reset_o), 32'h6);
    #3 reset_n_i = 1'b0;
    #1;
    chk("async reset_o", 32'(bus.reset_o), 32'h7);
    chk("async done_o", 32'(bus.done_o), 32'h0);
    chk("async relock", 32'(bus.relock_count_o), 32'h0);
    #1 reset_n_i = 1'b1;
    ecnt = 0;
    run_table(0, "post");
    chk("post relock", 32'(bus.relock_count_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
